// File: rtl/seq_detector_prog_pkg.sv
// Shared constants, width helper and configuration record for the programmable
// serial pattern detector.
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 8;
    localparam logic [DEF_MAX_LEN-1:0] DEF_PATTERN = 8'h0B;
    localparam int   DEF_LEN     = 4;
    localparam logic DEF_OVERLAP = 1'b1;

    // Bits needed to hold a length in 0..max_len inclusive.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Configuration record at the default geometry.
    typedef struct packed {
        logic [DEF_MAX_LEN-1:0]          pattern;
        logic [$clog2(DEF_MAX_LEN+1)-1:0] len;
        logic                             overlap;
    } cfg_t;

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with clear taking priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: loadable pattern/length, overlap control,
// valid-qualified input, registered detect pulse and saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = DEF_PATTERN,
    parameter int                 RST_LEN     = DEF_LEN,
    parameter logic               RST_OVERLAP = DEF_OVERLAP,
    localparam int                LW          = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LW-1:0]      len;
        logic               overlap;
    } det_cfg_t;

    localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
    localparam logic [LW-1:0] RST_LEN_L = (RST_LEN > MAX_LEN) ? MAX_LEN_L : LW'(RST_LEN);
    localparam det_cfg_t      RST_CFG   = '{pattern: RST_PATTERN, len: RST_LEN_L,
                                            overlap: RST_OVERLAP};

    det_cfg_t           cfg_q;
    logic [MAX_LEN-1:0] hist_q;
    logic [LW-1:0]      fill_q;
    logic               detected_q;

    logic               accept;
    logic [MAX_LEN-1:0] hist_next;
    logic [LW-1:0]      fill_next;
    logic [MAX_LEN-1:0] mask;
    logic               match;
    logic [LW-1:0]      load_len;

    assign accept    = in_valid && !cfg_load;
    assign hist_next = {hist_q[MAX_LEN-2:0], in_bit};
    assign fill_next = (fill_q == MAX_LEN_L) ? fill_q : fill_q + LW'(1);
    assign load_len  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;

    // Only the low len bits of the pattern take part in the compare.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(cfg_q.len));
        end
    end

    assign match = accept && (cfg_q.len != '0) && (fill_next >= cfg_q.len) &&
                   (((hist_next ^ cfg_q.pattern) & mask) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_q      <= RST_CFG;
            hist_q     <= '0;
            fill_q     <= '0;
            detected_q <= 1'b0;
        end else begin
            detected_q <= match;
            if (cfg_load) begin
                cfg_q  <= '{pattern: cfg_pattern, len: load_len, overlap: cfg_overlap};
                hist_q <= '0;
                fill_q <= '0;
            end else if (in_valid) begin
                hist_q <= hist_next;
                // Non-overlap restarts the fill so the next match needs len fresh bits.
                fill_q <= (match && !cfg_q.overlap) ? '0 : fill_next;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (match),
        .clr   (cnt_clr),
        .count (match_count)
    );

    assign detected = detected_q;
    assign armed    = (cfg_q.len != '0) &&
                      (({1'b0, fill_q} + (LW+1)'(1)) >= {1'b0, cfg_q.len});

endmodule
